// File: rtl/ezm_prog_feeder.sv
// ezm_prog_feeder: program store, CPU reset control and watchdog feeding instructions to the ezm core.
// Optional breakpoint logic is enabled by defining EZM_FEED_BKPT_EN.
module ezm_prog_feeder #(
    parameter int DEPTH      = 32,
    parameter int ADDR_W     = 5,
    parameter int MAX_CYCLES = 255,
    parameter int CYC_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [5:0]        wr_data_i,
    input  logic              run_i,
    input  logic              abort_i,
    input  logic [7:0]        pc_i,
`ifdef EZM_FEED_BKPT_EN
    input  logic              bkpt_en_i,
    input  logic [7:0]        bkpt_addr_i,
    output logic              bkpt_hit_o,
`endif
    output logic [5:0]        instr_o,
    output logic              cpu_rst_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              timeout_o,
    output logic [ADDR_W:0]   prog_len_o
);
    typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DONE} state_t;
    state_t state, state_n;
    logic [5:0] mem [DEPTH];
    logic [ADDR_W:0] prog_len, wr_len;
    logic [CYC_W-1:0] cnt;
    logic timeout, in_prog, wd_exp, bkpt;
    assign in_prog    = pc_i < 8'(prog_len);
    assign wd_exp     = cnt == CYC_W'(MAX_CYCLES - 1);
    assign wr_len     = {1'b0, wr_addr_i} + (ADDR_W + 1)'(1);
    assign timeout_o  = timeout;
    assign prog_len_o = prog_len;
`ifdef EZM_FEED_BKPT_EN
    logic bkpt_hit;
    assign bkpt       = bkpt_en_i && pc_i == bkpt_addr_i;
    assign bkpt_hit_o = bkpt_hit;
    always_ff @(posedge clk) begin
        if (rst)
            bkpt_hit <= 1'b0;
        else if (state == START || state_n == LOAD)
            bkpt_hit <= 1'b0;
        else if (state == RUN && !abort_i && bkpt)
            bkpt_hit <= 1'b1;
    end
`else
    assign bkpt = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = load_i ? LOAD : (run_i && prog_len != '0) ? START : IDLE;
            LOAD:    state_n = load_i ? LOAD : IDLE;
            START:   state_n = RUN;
            RUN:     state_n = abort_i ? IDLE : (bkpt || !in_prog || wd_exp) ? DONE : RUN;
            DONE:    state_n = abort_i ? IDLE : load_i ? LOAD : run_i ? START : DONE;
            default: state_n = IDLE;
        endcase
    end
    always_comb begin
        cpu_rst_o = state == IDLE || state == LOAD || state == START;
        busy_o    = state == START || state == RUN;
        done_o    = state == DONE;
        instr_o   = (state == RUN && in_prog && !bkpt) ? mem[pc_i[ADDR_W-1:0]] : 6'b0;
    end
    // The timeout flag is raised only when the watchdog is the actual reason for leaving RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            prog_len <= '0;
            cnt      <= '0;
            timeout  <= 1'b0;
        end else begin
            if (state == LOAD && wr_en_i) mem[wr_addr_i] <= wr_data_i;
            if (state != LOAD && state_n == LOAD)
                prog_len <= '0;
            else if (state == LOAD && wr_en_i && wr_len > prog_len)
                prog_len <= wr_len;
            cnt <= state == START ? '0 : state == RUN ? cnt + CYC_W'(1) : cnt;
            if (state == START || state_n == LOAD)
                timeout <= 1'b0;
            else if (state == RUN && !abort_i && !bkpt && in_prog && wd_exp)
                timeout <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ezm_prog_feeder.sv
// tb_ezm_prog_feeder: directed stimulus with a queued scoreboard for ezm_prog_feeder.
module tb_ezm_prog_feeder;
  logic clk = 0, rst = 1, load_i = 0, wr_en_i = 0, run_i = 0, abort_i = 0;
  logic [4:0] wr_addr_i = 0;
  logic [5:0] wr_data_i = 0;
  logic [7:0] pc_i = 0;
  logic [5:0] instr_o, prog_len_o;
  logic cpu_rst_o, busy_o, done_o, timeout_o, hit;
`ifdef EZM_FEED_BKPT_EN
  logic bkpt_en_i = 0, bkpt_hit_o;
  logic [7:0] bkpt_addr_i = 0;
  assign hit = bkpt_hit_o;
`else
  assign hit = 1'b0;
`endif
  ezm_prog_feeder dut (
    .clk(clk), .rst(rst), .load_i(load_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i), .run_i(run_i), .abort_i(abort_i), .pc_i(pc_i),
`ifdef EZM_FEED_BKPT_EN
    .bkpt_en_i(bkpt_en_i), .bkpt_addr_i(bkpt_addr_i), .bkpt_hit_o(bkpt_hit_o),
`endif
    .instr_o(instr_o), .cpu_rst_o(cpu_rst_o), .busy_o(busy_o), .done_o(done_o),
    .timeout_o(timeout_o), .prog_len_o(prog_len_o)
  );
  always #5 clk = ~clk;
  typedef struct {string name; logic [16:0] v;} exp_t;
  exp_t q[$];
  exp_t e;
  logic [16:0] act;
  int compared = 0, mismatched = 0;
  always @(negedge clk) begin
    while (q.size() != 0) begin
      e = q.pop_front();
      act = {instr_o, cpu_rst_o, busy_o, done_o, timeout_o, prog_len_o, hit};
      compared++;
      if (act !== e.v) begin
        mismatched++;
        $display("FAIL %s: got %b expected %b", e.name, act, e.v);
      end
    end
  end
  function automatic void chk(string n, logic [5:0] i, logic cr, logic b, logic d,
                              logic t, logic [5:0] pl, logic h = 1'b0);
    exp_t x;
    x.name = n;
    x.v = {i, cr, b, d, t, pl, h};
    q.push_back(x);
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [4:0] a, input logic [5:0] d, input logic last);
    wr_en_i = 1; wr_addr_i = a; wr_data_i = d; load_i = !last;
    tick;
    wr_en_i = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    tick; tick;
    chk("reset", 6'b0, 1, 0, 0, 0, 0);
    rst = 0;
    tick;
    load_i = 1; tick;
    chk("load_state", 6'b0, 1, 0, 0, 0, 0);
    wr(0, 6'b100011, 0);
    wr(1, 6'b001010, 0);
    wr(2, 6'b010010, 1);
    chk("load_len", 6'b0, 1, 0, 0, 0, 3);
    run_i = 1; tick; run_i = 0;
    chk("start", 6'b0, 1, 1, 0, 0, 3);
    tick;
    pc_i = 0; chk("run_pc0", 6'b100011, 0, 1, 0, 0, 3); tick;
    pc_i = 1; chk("run_pc1", 6'b001010, 0, 1, 0, 0, 3); tick;
    pc_i = 2; chk("run_pc2", 6'b010010, 0, 1, 0, 0, 3); tick;
    pc_i = 3; chk("run_pc3", 6'b0, 0, 1, 0, 0, 3); tick;
    chk("done", 6'b0, 0, 0, 1, 0, 3);
    compared++;
    if (done_o !== 1'b1) begin
      mismatched++;
      $display("FAIL done_direct: got %b expected 1", done_o);
    end
    abort_i = 1; tick; abort_i = 0;
    chk("done_abort", 6'b0, 1, 0, 0, 0, 3);
    wr_en_i = 1; wr_addr_i = 5; wr_data_i = 6'b111111; tick;
    wr_addr_i = 1; tick; wr_en_i = 0;
    chk("idle_wr_len", 6'b0, 1, 0, 0, 0, 3);
    run_i = 1; tick; run_i = 0; tick;
    pc_i = 1; chk("idle_wr_old", 6'b001010, 0, 1, 0, 0, 3); tick;
    pc_i = 2; tick;
    pc_i = 0; tick;
    pc_i = 1; abort_i = 1; chk("abort_cyc4", 6'b001010, 0, 1, 0, 0, 3); tick; abort_i = 0;
    chk("abort_idle", 6'b0, 1, 0, 0, 0, 3);
    load_i = 1; tick;
    chk("load_clr", 6'b0, 1, 0, 0, 0, 0);
    wr(0, 6'b011000, 0);
    wr(1, 6'b011000, 1);
    run_i = 1; tick; run_i = 0; tick;
    for (int k = 0; k < 255; k++) begin
      pc_i = 8'(k % 2);
      chk("wd_run", 6'b011000, 0, 1, 0, 0, 2);
      tick;
    end
    chk("timeout", 6'b0, 0, 0, 1, 1, 2);
    compared++;
    if (timeout_o !== 1'b1) begin
      mismatched++;
      $display("FAIL timeout_direct: got %b expected 1", timeout_o);
    end
    run_i = 1; tick; run_i = 0;
    chk("restart_start", 6'b0, 1, 1, 0, 1, 2);
    tick;
    pc_i = 0; chk("restart_clr", 6'b011000, 0, 1, 0, 0, 2); tick;
    rst = 1; tick; rst = 0;
    chk("rst_mid", 6'b0, 1, 0, 0, 0, 0);
    run_i = 1; tick; run_i = 0;
    chk("run_ignored", 6'b0, 1, 0, 0, 0, 0);
    load_i = 1; tick;
    wr(3, 6'b000111, 1);
    run_i = 1; tick; run_i = 0; tick;
    pc_i = 0; chk("cleared_pc0", 6'b0, 0, 1, 0, 0, 4);
    #1;
    compared++;
    if (instr_o !== 6'b0) begin
      mismatched++;
      $display("FAIL cleared_direct: got %b expected 000000", instr_o);
    end
    tick;
    pc_i = 1; chk("cleared_pc1", 6'b0, 0, 1, 0, 0, 4); tick;
    pc_i = 2; chk("cleared_pc2", 6'b0, 0, 1, 0, 0, 4); tick;
    pc_i = 3; chk("new_pc3", 6'b000111, 0, 1, 0, 0, 4); tick;
    pc_i = 4; tick;
    chk("done2", 6'b0, 0, 0, 1, 0, 4);
    load_i = 1; run_i = 1; tick; run_i = 0;
    chk("load_wins", 6'b0, 1, 0, 0, 0, 0);
`ifdef EZM_FEED_BKPT_EN
    wr(0, 6'b000001, 0);
    wr(1, 6'b000010, 0);
    wr(2, 6'b000011, 0);
    wr(3, 6'b000100, 1);
    bkpt_en_i = 1; bkpt_addr_i = 2;
    run_i = 1; tick; run_i = 0; tick;
    pc_i = 0; chk("bk_pc0", 6'b000001, 0, 1, 0, 0, 4, 0); tick;
    pc_i = 1; chk("bk_pc1", 6'b000010, 0, 1, 0, 0, 4, 0); tick;
    pc_i = 2; chk("bk_pc2", 6'b0, 0, 1, 0, 0, 4, 0); tick;
    chk("bk_done", 6'b0, 0, 0, 1, 0, 4, 1);
    bkpt_en_i = 0;
`endif
    load_i = 0;
    tick; tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
